// File: rtl/hdmi_pkg.sv
// Shared constants, packet types and bit-level helpers for the HDMI data-island path.
package hdmi_pkg;
  localparam logic [7:0] BCH_POLY   = 8'h83;
  localparam int         PKT_CYCLES = 32;
  localparam int         CS_FRAMES  = 192;
  localparam logic [7:0] PT_NULL    = 8'h00;
  localparam logic [7:0] PT_AUDIO   = 8'h02;

  typedef logic [23:0] hdr_t;
  typedef logic [55:0] sp_t;
  typedef enum logic {ST_IDLE, ST_SEND} st_t;

  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    return {1'b0, e[7:1]} ^ ((e[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

  // SB6 layout: {Pr, Cr, 0, 0, Pl, Cl, 0, 0}; parity covers sample and status bit
  function automatic sp_t audio_sp(input logic [23:0] l24, input logic [23:0] r24,
                                   input logic cl, input logic cr);
    logic pl, pr;
    pl = ^{l24, cl};
    pr = ^{r24, cr};
    return {pr, cr, 2'b00, pl, cl, 2'b00, r24, l24};
  endfunction
endpackage

// File: rtl/hdmi_bch8.sv
// Serial BCH ECC accumulator; consumes one or two bits per enabled cycle.
module hdmi_bch8
  import hdmi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       two,
  input  logic [1:0] d,
  output logic [7:0] ecc
);
  logic [7:0] r_e;
  logic [7:0] w_s1, w_s2;

  // Feeding e[0] (and e[1]) back as data yields a plain right shift for ECC readout.
  assign w_s1 = bch_step(r_e, d[0]);
  assign w_s2 = bch_step(w_s1, d[1]);
  assign ecc  = r_e;

  always_ff @(posedge clk)
    if (rst || clr) r_e <= '0;
    else if (en)    r_e <= two ? w_s2 : w_s1;
endmodule

// File: rtl/hdmi_island_packer.sv
// Data-island packet builder: sample FIFO, packet select (aux/audio/null), 32-cycle serialiser.
module hdmi_island_packer
  import hdmi_pkg::*;
#(
  parameter int           SAMPLE_W   = 16,
  parameter int           FIFO_DEPTH = 8,
  parameter int           MAX_SP     = 4,
  parameter logic [191:0] CS_L       = 192'h0202100004,
  parameter logic [191:0] CS_R       = 192'h0202200004
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [2*SAMPLE_W-1:0]         s_data,
  input  logic                          aux_valid,
  output logic                          aux_ready,
  input  logic [23:0]                   aux_hdr,
  input  logic [223:0]                  aux_body,
  input  logic                          slot_start,
  output logic                          busy,
  output logic                          pkt_first,
  output logic                          hdr_bit,
  output logic [3:0]                    ch1,
  output logic [3:0]                    ch2,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          slot_err
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FW  = AW + 1;
  localparam int NSP = 4;

  logic [2*SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr, r_rd;
  logic [FW-1:0]         r_fill;
  logic [7:0]            r_csb;
  st_t                   r_state;
  logic [4:0]            r_cnt;
  logic                  r_err;
  hdr_t                  r_hdr;
  sp_t [NSP-1:0]         r_sp;

  logic                  w_busy, w_push, w_accept, w_sel_aux, w_sel_aud, w_hbit;
  logic [2:0]            w_n, w_pop;
  logic [3:0]            w_present, w_b;
  logic [8:0]            w_csb_sum;
  logic [7:0]            w_ehdr;
  hdr_t                  w_aud_hdr;
  sp_t [NSP-1:0]         w_aud_sp;
  logic [NSP-1:0][1:0]   w_spbit;
  logic [NSP-1:0][7:0]   w_esp;

  assign w_busy    = (r_state == ST_SEND);
  assign w_push    = s_valid && s_ready;
  // The last SEND cycle may accept the next slot so packets run back to back.
  assign w_accept  = slot_start && (!w_busy || r_cnt == 5'(PKT_CYCLES-1));
  assign w_sel_aux = aux_valid && (r_fill < FW'(FIFO_DEPTH/2));
  assign w_sel_aud = !w_sel_aux && (r_fill != '0);
  assign w_n       = (r_fill >= FW'(MAX_SP)) ? 3'(MAX_SP) : 3'(r_fill);
  assign w_pop     = (w_accept && w_sel_aud) ? w_n : 3'd0;
  assign w_present = 4'((5'd1 << w_n) - 5'd1);
  assign w_csb_sum = {1'b0, r_csb} + 9'(w_n);
  assign w_aud_hdr = {w_b, 4'b0000, 4'b0000, w_present, PT_AUDIO};

  for (genvar k = 0; k < NSP; k++) begin : g_sp
    logic [AW-1:0]         w_idx;
    logic [2*SAMPLE_W-1:0] w_smp;
    logic [8:0]            w_c9;
    logic [7:0]            w_csbk;
    logic                  w_here;

    assign w_idx  = r_rd + AW'(k);
    assign w_smp  = r_mem[w_idx];
    assign w_c9   = {1'b0, r_csb} + 9'(k);
    assign w_csbk = (w_c9 >= 9'(CS_FRAMES)) ? 8'(w_c9 - 9'(CS_FRAMES)) : w_c9[7:0];
    assign w_here = (3'(k) < w_n);
    assign w_b[k] = w_here && (w_csbk == 8'd0);
    assign w_aud_sp[k] = w_here ?
      audio_sp(24'(w_smp[SAMPLE_W-1:0]) << (24-SAMPLE_W),
               24'(w_smp[2*SAMPLE_W-1:SAMPLE_W]) << (24-SAMPLE_W),
               CS_L[w_csbk], CS_R[w_csbk]) : '0;

    assign w_spbit[k] = (r_cnt < 5'd28) ? r_sp[k][1:0] : w_esp[k][1:0];
    assign ch1[k]     = w_busy && w_spbit[k][0];
    assign ch2[k]     = w_busy && w_spbit[k][1];

    hdmi_bch8 u_bch (
      .clk (clk), .rst (rst), .clr (w_accept), .en (w_busy),
      .two (1'b1), .d (w_spbit[k]), .ecc (w_esp[k])
    );
  end

  assign w_hbit = (r_cnt < 5'd24) ? r_hdr[0] : w_ehdr[0];

  hdmi_bch8 u_bch_hdr (
    .clk (clk), .rst (rst), .clr (w_accept), .en (w_busy),
    .two (1'b0), .d ({1'b0, w_hbit}), .ecc (w_ehdr)
  );

  assign busy      = w_busy;
  assign pkt_first = w_busy && (r_cnt == 5'd0);
  assign hdr_bit   = w_busy && w_hbit;
  assign fill      = r_fill;
  assign s_ready   = (r_fill != FW'(FIFO_DEPTH));
  assign slot_err  = r_err;
  assign aux_ready = !rst && w_accept && w_sel_aux;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_fill  <= '0;
      r_csb   <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_hdr   <= '0;
      r_sp    <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd   <= r_rd + AW'(w_pop);
      r_fill <= r_fill + FW'(w_push) - FW'(w_pop);
      if (w_pop != 3'd0)
        r_csb <= (w_csb_sum >= 9'(CS_FRAMES)) ? 8'(w_csb_sum - 9'(CS_FRAMES)) : w_csb_sum[7:0];
      if (slot_start && !w_accept) r_err <= 1'b1;

      if (w_accept) begin
        r_state <= ST_SEND;
        r_cnt   <= '0;
        if (w_sel_aux) begin
          r_hdr <= aux_hdr;
          r_sp  <= aux_body;
        end else if (w_sel_aud) begin
          r_hdr <= w_aud_hdr;
          r_sp  <= w_aud_sp;
        end else begin
          r_hdr <= {16'h0000, PT_NULL};
          r_sp  <= '0;
        end
      end else if (w_busy) begin
        r_cnt <= r_cnt + 5'd1;
        r_hdr <= r_hdr >> 1;
        for (int k = 0; k < NSP; k++) r_sp[k] <= r_sp[k] >> 2;
        if (r_cnt == 5'(PKT_CYCLES-1)) r_state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_hdmi_island_packer.sv
// Scoreboard bench: stimulus queues expected packets, a negedge monitor deserialises and compares.
module tb_hdmi_island_packer;
  localparam logic [191:0] CSL = 192'h0202100004;
  localparam logic [191:0] CSR = 192'h0202200004;

  logic         clk = 1'b0, rst = 1'b1;
  logic         s_valid = 1'b0, aux_valid = 1'b0, slot_start = 1'b0;
  logic [31:0]  s_data = '0;
  logic [23:0]  aux_hdr = '0;
  logic [223:0] aux_body = '0;
  logic         s_ready, aux_ready, busy, pkt_first, hdr_bit, slot_err;
  logic [3:0]   ch1, ch2, fill;

  hdmi_island_packer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_hdr(aux_hdr), .aux_body(aux_body),
    .slot_start(slot_start), .busy(busy), .pkt_first(pkt_first), .hdr_bit(hdr_bit),
    .ch1(ch1), .ch2(ch2), .fill(fill), .slot_err(slot_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] h; logic [3:0][63:0] sp; } pkt_t;
  pkt_t        sbq[$];
  logic [31:0] mq[$];
  int          csb = 0;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ecc_of(input logic [63:0] v, input int nb);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < nb; i++) e = {1'b0, e[7:1]} ^ ((e[0] ^ v[i]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  function automatic pkt_t mk_pkt(input logic [23:0] h, input logic [223:0] b);
    pkt_t p;
    p.h = {ecc_of({40'h0, h}, 24), h};
    for (int k = 0; k < 4; k++) p.sp[k] = {ecc_of({8'h0, b[56*k +: 56]}, 56), b[56*k +: 56]};
    return p;
  endfunction

  function automatic logic [55:0] model_sp(input logic [15:0] l, input logic [15:0] r, input int c);
    logic [23:0] l24, r24;
    logic cl, cr;
    l24 = {l, 8'h00}; r24 = {r, 8'h00};
    cl = CSL[c]; cr = CSR[c];
    return {^{r24, cr}, cr, 2'b00, ^{l24, cl}, cl, 2'b00, r24, l24};
  endfunction

  task automatic exp_audio(input int n);
    logic [223:0] b;
    logic [3:0]   bb;
    logic [31:0]  s;
    int           c;
    b = '0; bb = '0;
    for (int k = 0; k < n; k++) begin
      s = mq.pop_front();
      c = (csb + k) % 192;
      if (c == 0) bb[k] = 1'b1;
      b[56*k +: 56] = model_sp(s[15:0], s[31:16], c);
    end
    csb = (csb + n) % 192;
    sbq.push_back(mk_pkt({bb, 4'h0, 4'h0, 4'((1 << n) - 1), 8'h02}, b));
  endtask

  task automatic push_smp(input logic [15:0] l, input logic [15:0] r);
    logic acc;
    acc = (mq.size() < 8);
    @(posedge clk); #1 s_valid = 1'b1; s_data = {r, l};
    @(negedge clk); chk("s_ready", s_ready, acc);
    if (acc) mq.push_back({r, l});
    @(posedge clk); #1 s_valid = 1'b0;
  endtask

  task automatic do_slot(input logic exp_aux);
    @(posedge clk); #1 slot_start = 1'b1;
    @(negedge clk); chk("aux_ready", aux_ready, exp_aux);
    @(posedge clk); #1 slot_start = 1'b0;
  endtask

  task automatic wait_pkt;
    repeat (32) @(posedge clk);
    #1;
  endtask

  // Monitor: collects 32 cycles per packet; a packet cut short by reset is discarded.
  int               mcyc = -1;
  logic [31:0]      cap_h;
  logic [3:0][63:0] cap_sp;
  logic             pf_bad;
  pkt_t             me;

  always @(negedge clk) begin
    if (!busy) mcyc = -1;
    else begin
      if (mcyc < 0 || mcyc == 32) begin
        mcyc = 0;
        pf_bad = !pkt_first;
      end else if (pkt_first) pf_bad = 1'b1;
      cap_h[mcyc] = hdr_bit;
      for (int k = 0; k < 4; k++) begin
        cap_sp[k][2*mcyc]   = ch1[k];
        cap_sp[k][2*mcyc+1] = ch2[k];
      end
      mcyc++;
      if (mcyc == 32) begin
        if (sbq.size() == 0) chk("unexpected_pkt", 64'd1, 64'd0);
        else begin
          me = sbq.pop_front();
          chk("pkt_first", pf_bad, 1'b0);
          chk("hdr", cap_h, me.h);
          for (int k = 0; k < 4; k++) chk($sformatf("sp%0d", k), cap_sp[k], me.sp[k]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fill", fill, 4'd0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_slot_err", slot_err, 1'b0);
    chk("rst_aux_ready", aux_ready, 1'b0);
    chk("rst_outs", {hdr_bit, pkt_first, ch1, ch2}, 10'h0);

    // null packet
    sbq.push_back(mk_pkt(24'h0, '0));
    do_slot(1'b0);
    wait_pkt;

    // one sample, hand-computed header/subpacket 0
    push_smp(16'h1234, 16'h5678);
    chk("fill_1", fill, 4'd1);
    sbq.push_back(mk_pkt(24'h100102, {168'h0, 56'h08567800123400}));
    void'(mq.pop_front());
    csb = 1;
    do_slot(1'b0);
    @(negedge clk); chk("fill_0a", fill, 4'd0);
    wait_pkt;

    // six samples, two back-to-back packets
    for (int i = 0; i < 6; i++) push_smp(16'(16'h1000 + i), 16'(16'h2000 + i));
    chk("fill_6", fill, 4'd6);
    exp_audio(4);
    do_slot(1'b0);
    @(negedge clk); chk("fill_2", fill, 4'd2);
    repeat (30) @(posedge clk);
    exp_audio(2);
    do_slot(1'b0);
    @(negedge clk); chk("fill_0b", fill, 4'd0);
    chk("b2b_busy", busy, 1'b1);
    wait_pkt;

    // FIFO full: ninth push refused
    for (int i = 0; i < 9; i++) push_smp(16'(16'hA000 + i), 16'(16'hB000 + i));
    chk("fill_8", fill, 4'd8);
    chk("full_s_ready", s_ready, 1'b0);
    exp_audio(4); do_slot(1'b0); wait_pkt;
    exp_audio(4); do_slot(1'b0); wait_pkt;
    chk("fill_0c", fill, 4'd0);

    // run csb up to and across the 191 -> 0 wrap
    for (int p = 0; p < 45; p++) begin
      for (int i = 0; i < 4; i++) push_smp(16'(p*131 + i*7 + 3), 16'(~(p*131 + i)));
      exp_audio(4);
      do_slot(1'b0);
      wait_pkt;
    end

    // aux wins with fill = 2; payload held after handshake
    push_smp(16'h0A0A, 16'h0B0B);
    push_smp(16'h0C0C, 16'h0D0D);
    chk("fill_2b", fill, 4'd2);
    aux_valid = 1'b1;
    aux_hdr   = 24'h0D0284;
    aux_body  = {56'h11223344556677, 56'h8899AABBCCDDEE, 56'h0F1E2D3C4B5A69, 56'h0123456789ABCD};
    sbq.push_back(mk_pkt(aux_hdr, aux_body));
    do_slot(1'b1);
    aux_hdr  = 24'hFFFFFF;
    aux_body = {7{32'hDEADBEEF}};
    @(negedge clk);
    chk("aux_ready_once", aux_ready, 1'b0);
    chk("aux_fill", fill, 4'd2);
    wait_pkt;

    // audio wins with fill = 5
    for (int i = 0; i < 3; i++) push_smp(16'(16'h7000 + i), 16'(16'h7100 + i));
    chk("fill_5", fill, 4'd5);
    exp_audio(4);
    do_slot(1'b0);
    @(negedge clk); chk("fill_1b", fill, 4'd1);
    wait_pkt;
    aux_valid = 1'b0;
    exp_audio(1);
    do_slot(1'b0);
    wait_pkt;
    chk("fill_0d", fill, 4'd0);

    // slot_start mid-packet, then reset aborts the packet
    do_slot(1'b0);
    repeat (9) @(posedge clk);
    #1 slot_start = 1'b1;
    @(posedge clk); #1 slot_start = 1'b0;
    @(negedge clk);
    chk("slot_err", slot_err, 1'b1);
    chk("busy_mid", busy, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_outs", {hdr_bit, pkt_first, ch1, ch2}, 10'h0);
    chk("abort_slot_err", slot_err, 1'b0);
    chk("abort_fill", fill, 4'd0);

    repeat (40) @(posedge clk);
    chk("sb_empty", sbq.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
